// File: rtl/camera_register_file.sv
// Camera SPI register decoder with capture FSM, multi-byte zoom/pan writes,
// metering snapshots and a saturating image-buffer read pointer.
module camera_register_file #(
  parameter int ADDRESS_WIDTH     = 16,
  parameter int METERING_CHANNELS = 6
) (
  input  logic                           clock_in,
  input  logic                           reset_in,
  input  logic [7:0]                     opcode_in,
  input  logic                           opcode_valid_in,
  input  logic [7:0]                     operand_in,
  input  logic                           operand_valid_in,
  input  logic                           operand_read_in,
  input  logic [31:0]                    rd_operand_count_in,
  output logic [7:0]                     response_out,
  output logic                           start_capture_out,
  output logic                           capture_busy_out,
  input  logic                           image_ready_in,
  input  logic [ADDRESS_WIDTH-1:0]       final_image_address_in,
  input  logic [7:0]                     image_data_in,
  output logic [ADDRESS_WIDTH-1:0]       image_address_out,
  output logic                           image_address_valid_out,
  input  logic [8*METERING_CHANNELS-1:0] metering_in,
  output logic [2:0]                     compression_factor_out,
  output logic [15:0]                    zoom_out,
  output logic [15:0]                    pan_out,
  output logic                           power_save_enable_out,
  output logic                           gamma_bypass_out
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam int CB = (ADDRESS_WIDTH + 7) / 8;

  localparam logic [7:0] OP_START_CAPTURE   = 8'h20;
  localparam logic [7:0] OP_BYTES_REMAINING = 8'h21;
  localparam logic [7:0] OP_IMAGE_DATA      = 8'h22;
  localparam logic [7:0] OP_ZOOM            = 8'h23;
  localparam logic [7:0] OP_PAN             = 8'h24;
  localparam logic [7:0] OP_METERING        = 8'h25;
  localparam logic [7:0] OP_QUALITY_FACTOR  = 8'h26;
  localparam logic [7:0] OP_POWER_SAVE      = 8'h28;
  localparam logic [7:0] OP_IMAGE_READY     = 8'h30;
  localparam logic [7:0] OP_COMPRESSED      = 8'h31;
  localparam logic [7:0] OP_GAMMA_BYPASS    = 8'h32;

  typedef enum logic [1:0] {IDLE, CAPTURING, READY} state_t;

  state_t                         state, next_state;
  logic                           opcode_valid_q;
  logic                           opcode_rise;
  logic                           start_event;
  logic                           start_next;
  logic                           snapshot_take;
  logic [PW-1:0]                  pointer;
  logic [PW-1:0]                  total;
  logic [PW-1:0]                  remaining;
  logic                           pointer_inc;
  logic [1:0]                     write_count;
  logic [1:0]                     write_index;
  logic                           write_strobe;
  logic                           read_strobe;
  logic [7:0]                     zoom_shadow;
  logic [7:0]                     pan_shadow;
  logic [8*METERING_CHANNELS-1:0] snapshot;
  logic [31:0]                    remaining_ext;
  logic [31:0]                    final_ext;

  assign opcode_rise  = opcode_valid_in & ~opcode_valid_q;
  assign start_event  = opcode_rise & (opcode_in == OP_START_CAPTURE);
  assign write_strobe = opcode_valid_in & operand_valid_in;
  assign read_strobe  = opcode_valid_in & operand_read_in;

  // The byte index restarts at 0 on the opcode edge even before the counter register clears.
  assign write_index  = opcode_rise ? 2'd0 : write_count;

  assign total         = {1'b0, final_image_address_in} + PW'(4);
  assign remaining     = total - pointer;
  assign remaining_ext = 32'(remaining);
  assign final_ext     = 32'(final_image_address_in);

  assign pointer_inc = read_strobe & (opcode_in == OP_IMAGE_DATA) & (pointer < total);

  assign capture_busy_out  = (state == CAPTURING);
  assign image_address_out = pointer[ADDRESS_WIDTH-1:0];

  always_comb begin
    next_state    = state;
    start_next    = 1'b0;
    snapshot_take = 1'b0;
    case (state)
      IDLE, READY: begin
        if (start_event) begin
          next_state = CAPTURING;
          start_next = 1'b1;
        end
      end
      CAPTURING: begin
        if (image_ready_in) begin
          next_state    = READY;
          snapshot_take = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state             <= IDLE;
      start_capture_out <= 1'b0;
      opcode_valid_q    <= 1'b0;
      snapshot          <= '0;
    end else begin
      state             <= next_state;
      start_capture_out <= start_next;
      opcode_valid_q    <= opcode_valid_in;
      if (snapshot_take) snapshot <= metering_in;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      pointer                 <= '0;
      image_address_valid_out <= 1'b0;
    end else begin
      if (start_next)       pointer <= '0;
      else if (pointer_inc) pointer <= pointer + PW'(1);
      image_address_valid_out <= read_strobe &
                                 ((opcode_in == OP_IMAGE_DATA) ||
                                  (opcode_in == OP_BYTES_REMAINING) ||
                                  (opcode_in == OP_COMPRESSED));
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      write_count            <= '0;
      zoom_shadow            <= '0;
      pan_shadow             <= '0;
      zoom_out               <= '0;
      pan_out                <= '0;
      compression_factor_out <= '0;
      power_save_enable_out  <= 1'b0;
      gamma_bypass_out       <= 1'b0;
    end else begin
      if (write_strobe) begin
        if (write_index != 2'd2) write_count <= write_index + 2'd1;
        else                     write_count <= write_index;
      end else if (opcode_rise) begin
        write_count <= '0;
      end
      if (write_strobe) begin
        case (opcode_in)
          OP_ZOOM: begin
            if (write_index == 2'd0)      zoom_shadow <= operand_in;
            else if (write_index == 2'd1) zoom_out    <= {zoom_shadow, operand_in};
          end
          OP_PAN: begin
            if (write_index == 2'd0)      pan_shadow <= operand_in;
            else if (write_index == 2'd1) pan_out    <= {pan_shadow, operand_in};
          end
          OP_QUALITY_FACTOR: compression_factor_out <= operand_in[2:0];
          OP_POWER_SAVE:     power_save_enable_out  <= operand_in[0];
          OP_GAMMA_BYPASS:   gamma_bypass_out       <= operand_in[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    response_out = '0;
    case (opcode_in)
      OP_BYTES_REMAINING: begin
        case (rd_operand_count_in)
          32'd0:   response_out = 8'(remaining_ext >> 16);
          32'd1:   response_out = 8'(remaining_ext >> 8);
          32'd2:   response_out = 8'(remaining_ext);
          default: response_out = '0;
        endcase
      end
      OP_IMAGE_DATA: begin
        if (pointer < total) response_out = image_data_in;
      end
      OP_METERING: begin
        // Indices past the last channel keep returning the last channel.
        response_out = snapshot[8*(METERING_CHANNELS-1) +: 8];
        for (int unsigned i = 0; i < METERING_CHANNELS; i++) begin
          if (rd_operand_count_in == 32'(i)) response_out = snapshot[8*i +: 8];
        end
      end
      OP_IMAGE_READY: response_out = {7'b0, state == READY};
      OP_COMPRESSED: begin
        for (int unsigned i = 0; i < CB; i++) begin
          if (rd_operand_count_in == 32'(i)) response_out = 8'(final_ext >> (8*i));
        end
      end
      default: response_out = '0;
    endcase
  end

endmodule

// File: tb/tb_camera_register_file.sv
// Randomised scoreboard bench for camera_register_file against a behavioural
// model of the opcode map, capture sequencing and read pointer.
module tb_camera_register_file;
  localparam int AW = 16;
  localparam int CH = 6;

  logic            clk = 1'b0;
  logic            reset_in = 1'b0;
  logic [7:0]      opcode_in = '0;
  logic            opcode_valid_in = 1'b0;
  logic [7:0]      operand_in = '0;
  logic            operand_valid_in = 1'b0;
  logic            operand_read_in = 1'b0;
  logic [31:0]     rd_operand_count_in = '0;
  logic [7:0]      response_out;
  logic            start_capture_out;
  logic            capture_busy_out;
  logic            image_ready_in = 1'b0;
  logic [AW-1:0]   final_image_address_in = '0;
  logic [7:0]      image_data_in = '0;
  logic [AW-1:0]   image_address_out;
  logic            image_address_valid_out;
  logic [8*CH-1:0] metering_in = '0;
  logic [2:0]      compression_factor_out;
  logic [15:0]     zoom_out;
  logic [15:0]     pan_out;
  logic            power_save_enable_out;
  logic            gamma_bypass_out;

  camera_register_file #(.ADDRESS_WIDTH(AW), .METERING_CHANNELS(CH)) dut (
    .clock_in(clk), .reset_in(reset_in), .opcode_in(opcode_in),
    .opcode_valid_in(opcode_valid_in), .operand_in(operand_in),
    .operand_valid_in(operand_valid_in), .operand_read_in(operand_read_in),
    .rd_operand_count_in(rd_operand_count_in), .response_out(response_out),
    .start_capture_out(start_capture_out), .capture_busy_out(capture_busy_out),
    .image_ready_in(image_ready_in), .final_image_address_in(final_image_address_in),
    .image_data_in(image_data_in), .image_address_out(image_address_out),
    .image_address_valid_out(image_address_valid_out), .metering_in(metering_in),
    .compression_factor_out(compression_factor_out), .zoom_out(zoom_out),
    .pan_out(pan_out), .power_save_enable_out(power_save_enable_out),
    .gamma_bypass_out(gamma_bypass_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_op, m_wcnt, m_ptr, m_final;
  bit m_busy, m_ready;
  int m_zoom, m_pan, m_zsh, m_psh, m_qf, m_ps, m_gb;
  int m_snap [CH];

  int resp_q[$];
  int start_q[$];
  int addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe or pulse the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (operand_read_in && !reset_in) begin
      if (resp_q.size() == 0) check("response_unexpected", 1, 0);
      else check("response", {24'b0, response_out}, resp_q.pop_front());
    end
    if (start_capture_out) begin
      if (start_q.size() == 0) check("start_pulse_unexpected", 1, 0);
      else check("start_busy", {31'b0, capture_busy_out}, start_q.pop_front());
    end
    if (image_address_valid_out) begin
      if (addr_q.size() == 0) check("addr_valid_unexpected", 1, 0);
      else check("addr_valid_addr", {16'b0, image_address_out}, addr_q.pop_front());
    end
  end

  // One clock; the model applies capture-sequencing rules for this cycle first.
  task automatic tick(input bit start_req);
    if (start_req && !m_busy) begin
      start_q.push_back(1);
      m_busy  = 1;
      m_ready = 0;
      m_ptr   = 0;
    end else if (m_busy && image_ready_in) begin
      m_busy  = 0;
      m_ready = 1;
      for (int i = 0; i < CH; i++) m_snap[i] = int'(metering_in[8*i +: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_op = 0; m_wcnt = 0; m_ptr = 0; m_busy = 0; m_ready = 0;
    m_zoom = 0; m_pan = 0; m_zsh = 0; m_psh = 0; m_qf = 0; m_ps = 0; m_gb = 0;
    for (int i = 0; i < CH; i++) m_snap[i] = 0;
  endtask

  task automatic check_regs();
    check("zoom", {16'b0, zoom_out}, m_zoom);
    check("pan", {16'b0, pan_out}, m_pan);
    check("quality", {29'b0, compression_factor_out}, m_qf);
    check("power_save", {31'b0, power_save_enable_out}, m_ps);
    check("gamma_bypass", {31'b0, gamma_bypass_out}, m_gb);
    check("busy", {31'b0, capture_busy_out}, {31'b0, m_busy});
    check("pointer", {16'b0, image_address_out}, m_ptr & ((1 << AW) - 1));
  endtask

  task automatic do_reset();
    opcode_valid_in = 0; operand_valid_in = 0; operand_read_in = 0; image_ready_in = 0;
    tick(0); tick(0);
    reset_in = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_in = 0;
    model_reset();
    check_regs();
    check("reset_start", {31'b0, start_capture_out}, 0);
    check("reset_addr_valid", {31'b0, image_address_valid_out}, 0);
  endtask

  task automatic set_final(input int v);
    m_final = v;
    final_image_address_in = AW'(v);
  endtask

  task automatic set_ready();
    image_ready_in = 1;
    tick(0);
    image_ready_in = 0;
  endtask

  task automatic begin_txn(input int op);
    opcode_in = 8'(op);
    opcode_valid_in = 1;
    m_op = op;
    m_wcnt = 0;
    tick(op == 'h20);
  endtask

  task automatic end_txn();
    opcode_valid_in = 0;
    tick(0);
  endtask

  task automatic write_byte(input int b);
    operand_in = 8'(b);
    operand_valid_in = 1;
    case (m_op)
      'h23: if (m_wcnt == 0) m_zsh = b; else if (m_wcnt == 1) m_zoom = (m_zsh << 8) | b;
      'h24: if (m_wcnt == 0) m_psh = b; else if (m_wcnt == 1) m_pan = (m_psh << 8) | b;
      'h26: m_qf = b & 7;
      'h28: m_ps = b & 1;
      'h32: m_gb = b & 1;
      default: ;
    endcase
    m_wcnt++;
    tick(0);
    operand_valid_in = 0;
  endtask

  function automatic int exp_resp(input int op, input int idx, input int data);
    int total, rem;
    total = m_final + 4;
    rem = (total - m_ptr) & ((1 << (AW + 1)) - 1);
    case (op)
      'h21: return (idx < 3) ? ((rem >> (8 * (2 - idx))) & 255) : 0;
      'h22: return (m_ptr < total) ? data : 0;
      'h25: return (idx < CH) ? m_snap[idx] : m_snap[CH-1];
      'h30: return m_ready ? 1 : 0;
      'h31: return (idx < (AW + 7) / 8) ? ((m_final >> (8 * idx)) & 255) : 0;
      default: return 0;
    endcase
  endfunction

  task automatic read_byte(input int idx);
    int d;
    d = int'($urandom_range(0, 255));
    image_data_in = 8'(d);
    rd_operand_count_in = idx;
    resp_q.push_back(exp_resp(m_op, idx, d));
    if (m_op == 'h22 && m_ptr < m_final + 4) m_ptr++;
    if (m_op == 'h21 || m_op == 'h22 || m_op == 'h31) addr_q.push_back(m_ptr);
    operand_read_in = 1;
    tick(0);
    operand_read_in = 0;
  endtask

  task automatic write_txn(input int op, input int n, input int b0, input int b1, input int b2);
    begin_txn(op);
    if (n > 0) write_byte(b0);
    if (n > 1) write_byte(b1);
    if (n > 2) write_byte(b2);
    end_txn();
  endtask

  task automatic read_txn(input int op, input int n);
    begin_txn(op);
    for (int i = 0; i < n; i++) read_byte(i);
    end_txn();
  endtask

  task automatic random_meter();
    for (int i = 0; i < CH; i++) metering_in[8*i +: 8] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int ops [6] = '{'h21, 'h22, 'h25, 'h30, 'h31, 'h27};
    model_reset();
    set_final(0);
    reset_in = 1;
    @(posedge clk); #1;
    do_reset();

    // image_ready while idle is ignored
    set_ready();
    read_txn('h30, 1);
    set_final('h0FFC);
    read_txn('h21, 4);
    read_txn('h31, 3);

    // capture sequencing
    write_txn('h20, 0, 0, 0, 0);
    check_regs();
    write_txn('h20, 0, 0, 0, 0);
    check_regs();
    set_ready();
    read_txn('h30, 1);
    write_txn('h20, 0, 0, 0, 0);
    check_regs();

    write_txn('h23, 2, 'h12, 'h34, 0);
    write_txn('h24, 1, 'h56, 0, 0);
    check_regs();
    write_txn('h24, 3, 'hA5, 'h5A, 'hFF);
    check_regs();

    metering_in = 48'h665544332211;
    set_ready();
    random_meter();
    begin_txn('h25);
    for (int i = 0; i < CH; i++) read_byte(i);
    read_byte(9);
    end_txn();

    // pointer saturation with a 6-byte image
    set_final(2);
    write_txn('h20, 0, 0, 0, 0);
    set_ready();
    read_txn('h22, 8);
    check_regs();
    read_txn('h21, 3);

    // image_ready coincident with a start while READY: start wins, no snapshot
    random_meter();
    image_ready_in = 1;
    begin_txn('h20);
    image_ready_in = 0;
    end_txn();
    read_txn('h25, CH);
    read_txn('h30, 1);
    check_regs();

    // reset mid-ZOOM and mid-capture
    begin_txn('h23);
    write_byte('hAB);
    do_reset();
    write_txn('h23, 2, 'h9A, 'hBC, 0);
    check_regs();
    write_txn('h20, 0, 0, 0, 0);
    do_reset();

    write_txn('h55, 2, 'h77, 'h88, 0);
    read_txn('h55, 2);
    check_regs();

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 8))
        0: write_txn($urandom_range(0, 1) ? 'h23 : 'h24, $urandom_range(1, 3),
                     $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        1: begin
          int sel = $urandom_range(0, 2);
          write_txn(sel == 0 ? 'h26 : (sel == 1 ? 'h28 : 'h32), $urandom_range(1, 2),
                    $urandom_range(0, 255), $urandom_range(0, 255), 0);
        end
        2: write_txn('h20, 0, 0, 0, 0);
        3: begin random_meter(); set_ready(); end
        4: begin
          begin_txn(ops[$urandom_range(0, 5)]);
          for (int i = $urandom_range(0, 1); i < 5; i++) read_byte($urandom_range(0, 1) ? i : $urandom_range(0, 12));
          end_txn();
        end
        5: set_final($urandom_range(0, 3) == 0 ? $urandom_range(0, (1 << AW) - 5) : $urandom_range(0, 10));
        6: read_txn('h22, $urandom_range(1, 8));
        7: write_txn($urandom_range('h40, 'hFF), $urandom_range(0, 2), $urandom_range(0, 255),
                     $urandom_range(0, 255), 0);
        default: if ($urandom_range(0, 4) == 0) do_reset(); else tick(0);
      endcase
      check_regs();
    end

    tick(0); tick(0); tick(0);
    check("resp_queue_drained", resp_q.size(), 0);
    check("start_queue_drained", start_q.size(), 0);
    check("addr_queue_drained", addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/camera_register_file.md
# camera_register_file

Parametrised successor to the camera SPI register decoder. It sits between the SPI target and the camera/JPEG pipeline and decodes opcode/operand strobes into capture control and image-buffer readout. Over the first generation it adds:
- a capture state machine that rejects start commands while busy,
- 16-bit zoom and pan registers written as multi-byte operands,
- an image-address width and metering channel count set by parameters,
- metering values frozen at capture completion,
- a saturating image-read pointer.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, image buffer address width (legal range 9–24).
- METERING_CHANNELS, 6, number of 8-bit metering inputs (legal range 1–16).

Ports:
- clock_in  input  1  single clock; every register updates on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- opcode_in  input  8  current SPI opcode; stable for the whole transaction.
- opcode_valid_in  input  1  high for the whole transaction once the opcode byte is received.
- operand_in  input  8  written operand byte.
- operand_valid_in  input  1  one-cycle strobe per written byte.
- operand_read_in  input  1  one-cycle strobe after each read byte has been shifted out.
- rd_operand_count_in  input  32  index of the read byte within the transaction (0 = first byte).
- response_out  output  8  byte returned to the SPI target (combinational).
- start_capture_out  output  1  one-cycle capture start pulse.
- capture_busy_out  output  1  high while the FSM is in CAPTURING.
- image_ready_in  input  1  high once the compressed image is complete.
- final_image_address_in  input  ADDRESS_WIDTH  total image size minus 4.
- image_data_in  input  8  buffer byte at image_address_out.
- image_address_out  output  ADDRESS_WIDTH  buffer read pointer.
- image_address_valid_out  output  1  one-cycle pulse one cycle after a pointer advance request.
- metering_in  input  8*METERING_CHANNELS  channel i occupies bits [8i+7:8i].
- compression_factor_out  output  3  quality factor.
- zoom_out  output  16  zoom value.
- pan_out  output  16  pan value.
- power_save_enable_out  output  1  D-PHY power save.
- gamma_bypass_out  output  1  debug gamma bypass.

## Operation
Opcodes:
- Write-only: 0x20 START_CAPTURE, 0x23 ZOOM, 0x24 PAN, 0x26 QUALITY_FACTOR, 0x28 POWER_SAVE_ENABLE, 0x32 GAMMA_BYPASS.
- Read-only: 0x21 BYTES_REMAINING, 0x22 IMAGE_DATA, 0x25 METERING, 0x30 IMAGE_READY_FLAG, 0x31 COMPRESSED_BYTES.
- All other opcodes are no-ops: response_out = 0 and no state changes.

Capture FSM (states IDLE, CAPTURING, READY):
- Start event: rising edge of opcode_valid_in with opcode_in = 0x20, detected against a registered copy of opcode_valid_in.
- IDLE or READY + start event → CAPTURING. In the same cycle: start_capture_out = 1 and the pointer clears to 0.
- A start event while in CAPTURING is ignored: no pulse and no state change.
- CAPTURING + image_ready_in = 1 → READY. On that transition every metering channel is copied into the snapshot registers.

Register writes:
- A write byte counter clears on the rising edge of opcode_valid_in and increments on each operand_valid_in.
- ZOOM and PAN take two bytes, MSB first. Byte 0 goes to a shadow register. Byte 1 commits the full 16 bits to the output. Extra bytes are ignored.
- A transaction that ends after one byte leaves the output unchanged.
- QUALITY_FACTOR loads operand_in[2:0]; POWER_SAVE_ENABLE and GAMMA_BYPASS load operand_in[0]. Each updates on every strobe.

Read responses:
- Arithmetic: total = final_image_address_in + 4 and remaining = total − image_address_out, both computed at ADDRESS_WIDTH+1 bits.
- BYTES_REMAINING: remaining, MSB first, left-padded to 3 bytes. Indices ≥ 3 return 0.
- IMAGE_DATA: image_data_in while image_address_out < total, else 0x00.
- METERING: index i < METERING_CHANNELS returns snapshot channel i; higher indices return the last channel.
- IMAGE_READY_FLAG: {7'b0, state == READY}.
- COMPRESSED_BYTES: final_image_address_in, LSB first, ceil(ADDRESS_WIDTH/8) bytes. Higher indices return 0.

Image read pointer:
- operand_read_in with IMAGE_DATA and image_address_out < total increments the pointer by 1.
- The pointer saturates at total and never wraps.
- image_address_valid_out pulses one cycle after operand_read_in when the opcode is IMAGE_DATA, BYTES_REMAINING or COMPRESSED_BYTES, even at saturation.

## Timing
Values after reset:
- All outputs 0 and FSM = IDLE.
- zoom_out, pan_out, shadow registers, snapshots and pointer all 0.
- response_out follows the combinational decode of these reset values.

Latencies:
- start_capture_out rises in the cycle after opcode_valid_in rises.
- A register write is visible on its output the cycle after the strobe.
- response_out is combinational, with zero latency from the inputs.

Simultaneous and boundary events:
- Start event together with an increment request: the clear wins.
- image_ready_in together with a start event while in READY: the start wins and no new snapshot is taken.
- Reset mid-capture or mid-write: everything returns to reset values and partial ZOOM/PAN shadows are discarded.
- image_ready_in held high while IDLE is ignored.

## Test plan
- Reset, then read 0x30 → 0x00. Read 0x21 with final = 0x0FFC → bytes 0x00, 0x10, 0x00.
- Send 0x20 → one start pulse and capture_busy_out = 1. Send a second 0x20 while busy → no pulse. Assert image_ready_in → 0x30 reads 0x01 and a second 0x20 gives a fresh pulse.
- ZOOM bytes 0x12, 0x34 → zoom_out = 0x1234. PAN with the single byte 0x56, then end the transaction → pan_out stays 0x0000.
- Hold metering inputs at 0x11…0x66 and complete a capture, then change the inputs → METERING returns 0x11…0x66. Read index 9 → 0x66.
- Final = 0x0002 (total 6): issue 8 IMAGE_DATA reads → pointer reaches 6 and stays there, the last two reads return 0x00 and remaining reads 0.
- Reset mid-ZOOM after byte 0 → zoom_out = 0. The next two-byte write commits normally.
